// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EX-stage branch resolve unit: funct3 codes,
// BHT counter type and states, FSM state encoding.
package branch_resolve_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t SNT = 2'b00;
    localparam bht_cnt_t WNT = 2'b01;
    localparam bht_cnt_t WT  = 2'b10;
    localparam bht_cnt_t ST  = 2'b11;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } bru_state_e;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t nxt;
        if (taken) begin
            nxt = (cnt == ST) ? ST : cnt + 2'd1;
        end else begin
            nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage control-flow bundle between the pipeline (master) and the
// branch resolve unit (slave), including the IF-side BHT lookup port.
interface branch_resolve_unit_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             valid;
    logic             stall;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic [2:0]       funct3;
    logic             br_less;
    logic             br_equal;
    logic             br_un;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic [PC_W-1:0]  lookup_pc;
    logic             lookup_taken;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport slave (
        input  valid, stall, is_branch, is_jal, is_jalr, funct3, br_less, br_equal,
               pc, target, pred_taken, pred_target, lookup_pc,
        output br_un, lookup_taken, redirect, redirect_pc, flush, branch_cnt, mispredict_cnt
    );

    modport master (
        output valid, stall, is_branch, is_jal, is_jalr, funct3, br_less, br_equal,
               pc, target, pred_taken, pred_target, lookup_pc,
        input  br_un, lookup_taken, redirect, redirect_pc, flush, branch_cnt, mispredict_cnt
    );

endinterface

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters, one registered update
// port and one combinational read port (read sees the pre-update value).
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            lookup_taken
);

    localparam int ENTRIES = 2 ** IDX_W;

    bht_cnt_t         table_r [ENTRIES];
    logic [IDX_W-1:0] upd_idx_s;
    logic [IDX_W-1:0] lookup_idx_s;
    logic             unused_pc_bits_s;

    assign upd_idx_s        = upd_pc[IDX_W+1:2];
    assign lookup_idx_s     = lookup_pc[IDX_W+1:2];
    assign unused_pc_bits_s = ^{upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0],
                                lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};
    assign lookup_taken     = table_r[lookup_idx_s][1];

    // Counter array: all entries weakly not-taken out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= WNT;
            end
        end else if (upd_en) begin
            table_r[upd_idx_s] <= bht_next(table_r[upd_idx_s], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decodes the actual outcome, detects mispredicts,
// issues a one-cycle registered redirect/flush and trains the BHT.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);

    bru_state_e       state_r;
    logic             redirect_r;
    logic [PC_W-1:0]  redirect_pc_r;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispredict_cnt_r;

    logic             accept_s;
    logic             taken_s;
    logic             legal_s;
    logic             cond_upd_s;
    logic             mispredict_s;
    logic [PC_W-1:0]  res_target_s;
    logic [PC_W-1:0]  correct_pc_s;

    // Shadow cycle (REDIRECT) blocks acceptance of the wrong-path instruction.
    assign accept_s = bus.valid & ~bus.stall & (state_r == RUN);

    // Outcome decode; jumps take priority over the conditional-branch flag.
    always_comb begin
        taken_s      = 1'b0;
        legal_s      = 1'b0;
        res_target_s = bus.target;
        if (bus.is_jal) begin
            taken_s = 1'b1;
            legal_s = 1'b1;
        end else if (bus.is_jalr) begin
            taken_s      = 1'b1;
            legal_s      = 1'b1;
            res_target_s = {bus.target[PC_W-1:1], 1'b0};
        end else if (bus.is_branch) begin
            legal_s = 1'b1;
            case (bus.funct3)
                F3_BEQ:           taken_s = bus.br_equal;
                F3_BNE:           taken_s = ~bus.br_equal;
                F3_BLT, F3_BLTU:  taken_s = bus.br_less;
                F3_BGE, F3_BGEU:  taken_s = ~bus.br_less;
                default: begin
                    taken_s = 1'b0;
                    legal_s = 1'b0;
                end
            endcase
        end else begin
            legal_s = 1'b0;
        end
    end

    assign cond_upd_s   = accept_s & bus.is_branch & ~bus.is_jal & ~bus.is_jalr & legal_s;
    assign mispredict_s = (taken_s != bus.pred_taken) |
                          (taken_s & (res_target_s != bus.pred_target));
    assign correct_pc_s = taken_s ? res_target_s
                                  : bus.pc + {{(PC_W-3){1'b0}}, 3'd4};

    // Redirect FSM: one registered pulse, then back to RUN regardless of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RUN;
            redirect_r    <= 1'b0;
            redirect_pc_r <= {PC_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (accept_s && mispredict_s) begin
                        state_r       <= REDIRECT;
                        redirect_r    <= 1'b1;
                        redirect_pc_r <= correct_pc_s;
                    end else begin
                        redirect_r <= 1'b0;
                    end
                end
                REDIRECT: begin
                    state_r    <= RUN;
                    redirect_r <= 1'b0;
                end
                default: begin
                    state_r    <= RUN;
                    redirect_r <= 1'b0;
                end
            endcase
        end
    end

    // Statistics counters, wrapping naturally at their width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_r     <= {CNT_W{1'b0}};
            mispredict_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && legal_s) begin
                branch_cnt_r <= branch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (accept_s && mispredict_s) begin
                mispredict_cnt_r <= mispredict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    bht_2bit #(
        .IDX_W (BHT_IDX_W),
        .PC_W  (PC_W)
    ) u_bht (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_en       (cond_upd_s),
        .upd_pc       (bus.pc),
        .upd_taken    (taken_s),
        .lookup_pc    (bus.lookup_pc),
        .lookup_taken (bus.lookup_taken)
    );

    assign bus.br_un          = bus.funct3[1];
    assign bus.redirect       = redirect_r;
    assign bus.flush          = redirect_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.branch_cnt     = branch_cnt_r;
    assign bus.mispredict_cnt = mispredict_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: mispredict redirect,
// shadow squash, BHT saturation, JALR alignment, stall and mid-pulse reset.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.PC_W(32), .CNT_W(32)) bus ();

    branch_resolve_unit #(.PC_W(32), .BHT_IDX_W(6), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.valid = 1'b0;       bus.stall = 1'b0;
        bus.is_branch = 1'b0;   bus.is_jal = 1'b0;   bus.is_jalr = 1'b0;
        bus.funct3 = 3'b000;    bus.br_less = 1'b0;  bus.br_equal = 1'b0;
        bus.pc = 32'h0;         bus.target = 32'h0;
        bus.pred_taken = 1'b0;  bus.pred_target = 32'h0;
        bus.lookup_pc = 32'h0;
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic less, input logic eq, input logic pt, input logic [31:0] ptgt);
        idle();
        bus.valid = 1'b1;  bus.is_branch = 1'b1;  bus.funct3 = f3;
        bus.pc = pc;       bus.target = tgt;
        bus.br_less = less; bus.br_equal = eq;
        bus.pred_taken = pt; bus.pred_target = ptgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        bus.lookup_pc = 32'h44;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect", 64'(bus.redirect), 64'h0);
        chk("rst_flush", 64'(bus.flush), 64'h0);
        chk("rst_redirect_pc", 64'(bus.redirect_pc), 64'h0);
        chk("rst_branch_cnt", 64'(bus.branch_cnt), 64'h0);
        chk("rst_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h0);
        chk("rst_lookup", 64'(bus.lookup_taken), 64'h0);
        rst_n = 1'b1;

        // BEQ taken, predicted not taken -> redirect to target
        br(F3_BEQ, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("beq_redirect", 64'(bus.redirect), 64'h1);
        chk("beq_flush", 64'(bus.flush), 64'h1);
        chk("beq_redirect_pc", 64'(bus.redirect_pc), 64'h140);
        chk("beq_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h1);
        chk("beq_branch_cnt", 64'(bus.branch_cnt), 64'h1);
        idle();
        bus.lookup_pc = 32'h100;
        #1;
        chk("beq_bht_idx0", 64'(bus.lookup_taken), 64'h1);
        step();
        chk("beq_pulse_end", 64'(bus.redirect), 64'h0);

        // Comparator unsigned select follows funct3[1]
        bus.funct3 = F3_BLTU;
        #1;
        chk("bltu_br_un", 64'(bus.br_un), 64'h1);
        bus.funct3 = F3_BGE;
        #1;
        chk("bge_br_un", 64'(bus.br_un), 64'h0);

        // BGE with less=1 is not taken; predicted taken -> fall through
        br(F3_BGE, 32'h200, 32'h300, 1'b1, 1'b0, 1'b1, 32'h300);
        step();
        chk("bge_redirect", 64'(bus.redirect), 64'h1);
        chk("bge_redirect_pc", 64'(bus.redirect_pc), 64'h204);
        chk("bge_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h2);
        // Wrong-path JAL in the shadow cycle must be ignored
        idle();
        bus.valid = 1'b1;  bus.is_jal = 1'b1;
        bus.pc = 32'h300;  bus.target = 32'h400;
        step();
        chk("shadow_redirect", 64'(bus.redirect), 64'h0);
        chk("shadow_branch_cnt", 64'(bus.branch_cnt), 64'h2);
        chk("shadow_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h2);

        // Correctly predicted BNE
        br(F3_BNE, 32'h40, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80);
        step();
        chk("bne_redirect", 64'(bus.redirect), 64'h0);
        chk("bne_branch_cnt", 64'(bus.branch_cnt), 64'h3);
        chk("bne_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h2);

        // BHT saturation on pc 0x44 (index 17)
        for (int i = 0; i < 4; i++) begin
            br(F3_BEQ, 32'h44, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10);
            step();
        end
        bus.lookup_pc = 32'h44;
        #1;
        chk("sat_lookup_st", 64'(bus.lookup_taken), 64'h1);
        chk("sat_branch_cnt", 64'(bus.branch_cnt), 64'h7);
        chk("sat_no_redirect", 64'(bus.redirect), 64'h0);
        br(F3_BEQ, 32'h44, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.lookup_pc = 32'h44;
        step();
        chk("nt_once_lookup", 64'(bus.lookup_taken), 64'h1);
        #1;
        chk("nt_no_bypass", 64'(bus.lookup_taken), 64'h1);
        step();
        chk("nt_twice_lookup", 64'(bus.lookup_taken), 64'h0);
        chk("nt_branch_cnt", 64'(bus.branch_cnt), 64'h9);

        // Illegal funct3: no count, no BHT update, no redirect
        br(3'b010, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0);
        bus.lookup_pc = 32'h40;
        step();
        chk("illegal_branch_cnt", 64'(bus.branch_cnt), 64'h9);
        chk("illegal_redirect", 64'(bus.redirect), 64'h0);
        chk("illegal_lookup", 64'(bus.lookup_taken), 64'h1);

        // JALR clears bit0 of the target: predicted 0x1002 is correct
        idle();
        bus.valid = 1'b1;  bus.is_jalr = 1'b1;
        bus.pc = 32'h500;  bus.target = 32'h1003;
        bus.pred_taken = 1'b1;  bus.pred_target = 32'h1002;
        step();
        chk("jalr_redirect", 64'(bus.redirect), 64'h0);
        chk("jalr_branch_cnt", 64'(bus.branch_cnt), 64'hA);
        chk("jalr_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h2);

        // Mispredicted JALR held by stall, then released
        bus.pred_taken = 1'b0;  bus.pred_target = 32'h0;
        bus.stall = 1'b1;
        step();
        step();
        chk("stall_redirect", 64'(bus.redirect), 64'h0);
        chk("stall_branch_cnt", 64'(bus.branch_cnt), 64'hA);
        chk("stall_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h2);
        bus.stall = 1'b0;
        step();
        chk("unstall_redirect", 64'(bus.redirect), 64'h1);
        chk("unstall_redirect_pc", 64'(bus.redirect_pc), 64'h1002);
        chk("unstall_branch_cnt", 64'(bus.branch_cnt), 64'hB);
        chk("unstall_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h3);

        // Reset asserted during the REDIRECT cycle aborts the pulse at once
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_redirect", 64'(bus.redirect), 64'h0);
        chk("midrst_flush", 64'(bus.flush), 64'h0);
        chk("midrst_redirect_pc", 64'(bus.redirect_pc), 64'h0);
        chk("midrst_branch_cnt", 64'(bus.branch_cnt), 64'h0);
        chk("midrst_mispredict_cnt", 64'(bus.mispredict_cnt), 64'h0);
        step();
        rst_n = 1'b1;
        bus.lookup_pc = 32'h40;
        step();
        chk("post_rst_lookup", 64'(bus.lookup_taken), 64'h0);
        chk("post_rst_redirect", 64'(bus.redirect), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage consumer of the branch comparator's `less`/`equal` results.
- Decodes funct3 into the actual branch outcome and checks it against the IF-stage prediction.
- On a mispredict, issues a registered one-cycle redirect and flush, then squashes the wrong-path shadow instruction.
- Owns a 2-bit saturating branch history table (BHT) with a combinational IF lookup port, plus branch and mispredict statistics counters.

Parameters:
- PC_W, 32, width of PC and target buses.
- BHT_IDX_W, 6, log2 of BHT entry count (64 entries).
- CNT_W, 32, width of the statistics counters.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-low reset.
- i_valid  in  1  EX holds a valid control-flow instruction.
- i_stall  in  1  EX stage held; instruction not accepted this cycle.
- i_is_branch  in  1  conditional branch.
- i_is_jal  in  1  JAL.
- i_is_jalr  in  1  JALR.
- i_funct3  in  3  branch funct3.
- i_br_less  in  1  comparator less result.
- i_br_equal  in  1  comparator equal result.
- o_br_un  out  1  comparator unsigned select, = i_funct3[1], combinational.
- i_pc  in  PC_W  PC of the EX instruction.
- i_target  in  PC_W  ALU-computed target.
- i_pred_taken  in  1  prediction carried down from IF.
- i_pred_target  in  PC_W  predicted target carried from IF.
- i_lookup_pc  in  PC_W  IF fetch PC for BHT lookup.
- o_lookup_taken  out  1  BHT prediction, combinational.
- o_redirect  out  1  one-cycle redirect pulse, registered.
- o_redirect_pc  out  PC_W  corrected fetch PC, registered.
- o_flush  out  1  clear IF/ID and ID/EX; equals o_redirect.
- o_branch_cnt  out  CNT_W  resolved control-flow instructions.
- o_mispredict_cnt  out  CNT_W  mispredicts.

Behaviour:
- **Reset** (async, i_reset=0):
  - FSM goes to RUN; o_redirect=0, o_redirect_pc=0, counters=0.
  - Every BHT entry is set to 2'b01 (weakly not-taken).
- **Accept condition:** accept = i_valid & ~i_stall & (state==RUN).
- **Outcome decode**, conditional branch:
  - 000 → equal.
  - 001 → ~equal.
  - 100 and 110 → less.
  - 101 and 111 → ~less.
  - 010 and 011 → illegal: not taken, no BHT update, not counted.
- **Outcome decode**, jumps:
  - JAL/JALR are always taken.
  - JALR target = i_target with bit0 cleared.
- **Mispredict condition:** (taken != i_pred_taken) | (taken & target != i_pred_target).
- **Correct PC:** taken ? target : i_pc+4, computed modulo 2^PC_W.
- **FSM** (RUN, REDIRECT):
  - RUN, accept & mispredict → REDIRECT. At this edge o_redirect←1 and o_redirect_pc←correct PC.
  - REDIRECT → RUN unconditionally after exactly one cycle, even if i_stall=1. o_redirect←0.
  - REDIRECT is the shadow cycle: i_valid is ignored. The wrong-path instruction in EX causes no redirect, no BHT update and no count.
- **Pipeline obligation:** o_flush overrides stall in the pipeline registers, and o_redirect has priority over PC+4 in fetch.
- **Redirect latency:** 1 cycle from the accept edge.
- **BHT:**
  - Index = pc[BHT_IDX_W+1:2].
  - Update on accept of a legal conditional branch: taken → saturating +1 (max 11); not taken → saturating −1 (min 00).
  - JAL/JALR do not update.
  - o_lookup_taken = bht[idx(i_lookup_pc)][1].
  - A write to the same index in the same cycle does not bypass: the lookup returns the old value.
- **Counters:**
  - o_branch_cnt increments on each accepted legal branch or jump.
  - o_mispredict_cnt increments on accept & mispredict.
  - Both wrap at 2^CNT_W.
- **Stall:** while i_stall=1 in RUN, all state is held.
- **Reset mid-REDIRECT:** the pulse is aborted and outputs go to their reset values immediately.

Decomposition:
- Shared package holds:
  - funct3 constants (F3_BEQ..F3_BGEU).
  - BHT counter typedef (2-bit) and constants SNT=00, WNT=01, WT=10, ST=11.
  - FSM state enum bru_state_e {RUN, REDIRECT}.
- One natural sub-module: bht_2bit, the counter array with its update and read port. Outcome decode and FSM stay in the top level.

Test Plan:
- BEQ at pc=0x100, equal=1, target=0x140, pred_taken=0, accepted → next cycle o_redirect=1, o_flush=1, o_redirect_pc=0x140; o_mispredict_cnt=1; bht[0x40>>... idx 0]=10.
- BLTU with i_funct3=110 → o_br_un=1. Then BGE pc=0x200, less=1, pred_taken=1 → not taken, redirect_pc=0x204. The following cycle (REDIRECT) presents a valid JAL → no redirect and o_branch_cnt unchanged.
- Correct prediction: BNE, equal=0, pred_taken=1, pred_target=target=0x80 → o_redirect stays 0; o_branch_cnt increments and o_mispredict_cnt does not.
- BHT saturation: same PC taken 4 times → counter 11 and o_lookup_taken=1. Then not-taken once → 10 and lookup still 1. From reset, the lookup of any PC = 0.
- JALR target=0x1003, pred_target=0x1002, pred_taken=1 → resolved target 0x1002, no mispredict. Same case with i_stall=1 → nothing counted until stall drops.
- Assert i_reset=0 during the REDIRECT cycle → o_redirect=0 immediately and counters=0. After release, lookup of a previously trained PC returns 0.
